// File: rtl/mc_controller.sv
// Multicycle control FSM: sequences instruction phases and decodes op/funct into datapath controls.
// Optional BNE support is enabled by defining MC_CTRL_BNE_EN.
module mc_controller #(
    parameter int MEM_WAIT = 0,
    parameter int WAIT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BEQ,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
`ifdef MC_CTRL_BNE_EN
        , S_BNE
`endif
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              bad_funct_q, bad_funct_d;

    logic       wait_last;
    logic [2:0] funct_alu;
    logic       funct_unknown;

    logic pcwrite_c, branch_eq_c, branch_ne_c;
    logic iord_c, memwrite_c, irwrite_c, regdst_c, memtoreg_c, regwrite_c, alusrca_c;
    logic [1:0] alusrcb_c, pcsrc_c;
    logic [2:0] alucontrol_c;

    assign wait_last = (wait_q == WAIT_LAST);

    always_comb begin
        funct_alu     = ALU_ADD;
        funct_unknown = 1'b0;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100100: funct_alu = ALU_AND;
            6'b100111: funct_alu = ALU_NOT;
            6'b100010: funct_alu = ALU_SUB;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_unknown = 1'b1;
        endcase
    end

    // Memory-facing states hold until the wait counter reaches MEM_WAIT, then clear it on exit.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        bad_funct_d = bad_funct_q;
        case (state_q)
            S_FETCH: begin
                if (wait_last) begin
                    wait_d  = '0;
                    state_d = S_DECODE;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BNE;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (wait_last) begin
                    wait_d  = '0;
                    state_d = S_MEMWB;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            S_MEMWR: begin
                if (wait_last) begin
                    wait_d  = '0;
                    state_d = S_FETCH;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            S_EXECUTE: begin
                bad_funct_d = funct_unknown;
                state_d     = S_ALUWB;
            end
            S_ADDIEX: state_d = S_ADDIWB;
            default: begin
                wait_d  = '0;
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            wait_q      <= '0;
            bad_funct_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            bad_funct_q <= bad_funct_d;
        end
    end

    always_comb begin
        pcwrite_c    = 1'b0;
        branch_eq_c  = 1'b0;
        branch_ne_c  = 1'b0;
        iord_c       = 1'b0;
        memwrite_c   = 1'b0;
        irwrite_c    = 1'b0;
        regdst_c     = 1'b0;
        memtoreg_c   = 1'b0;
        regwrite_c   = 1'b0;
        alusrca_c    = 1'b0;
        alusrcb_c    = 2'b00;
        pcsrc_c      = 2'b00;
        alucontrol_c = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                alusrcb_c = 2'b01;
                irwrite_c = wait_last;
                pcwrite_c = wait_last;
            end
            S_DECODE: alusrcb_c = 2'b11;
            S_MEMADR: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
            end
            S_MEMRD: iord_c = 1'b1;
            S_MEMWB: begin
                regwrite_c = 1'b1;
                memtoreg_c = 1'b1;
            end
            S_MEMWR: begin
                iord_c     = 1'b1;
                memwrite_c = wait_last;
            end
            S_EXECUTE: begin
                alusrca_c    = 1'b1;
                alucontrol_c = funct_alu;
            end
            S_ALUWB: begin
                regwrite_c = ~bad_funct_q;
                regdst_c   = 1'b1;
            end
            S_BEQ: begin
                alusrca_c    = 1'b1;
                alucontrol_c = ALU_SUB;
                pcsrc_c      = 2'b01;
                branch_eq_c  = 1'b1;
            end
`ifdef MC_CTRL_BNE_EN
            S_BNE: begin
                alusrca_c    = 1'b1;
                alucontrol_c = ALU_SUB;
                pcsrc_c      = 2'b01;
                branch_ne_c  = 1'b1;
            end
`endif
            S_ADDIEX: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
            end
            S_ADDIWB: regwrite_c = 1'b1;
            S_JUMP: begin
                pcsrc_c   = 2'b10;
                pcwrite_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are forced low while reset is asserted; the zero term is the only Mealy path.
    assign pcen       = ~reset & (pcwrite_c | (branch_eq_c & zero) | (branch_ne_c & ~zero));
    assign irwrite    = ~reset & irwrite_c;
    assign memwrite   = ~reset & memwrite_c;
    assign regwrite   = ~reset & regwrite_c;
    assign iord       = iord_c;
    assign regdst     = regdst_c;
    assign memtoreg   = memtoreg_c;
    assign alusrca    = alusrca_c;
    assign alusrcb    = alusrcb_c;
    assign pcsrc      = pcsrc_c;
    assign alucontrol = alucontrol_c;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: an instruction-level model queues per-cycle expected
// controls, and a negedge monitor pops and compares them against the DUT outputs.
module tb_mc_controller;

    localparam int MW = 2;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluctl;
    } outs_t;

    typedef struct {
        outs_t e;
        outs_t m;
        int    instr;
        int    cyc;
    } entry_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    outs_t  act;
    entry_t exp_q[$];
    entry_t model_q[$];
    entry_t mon_x;
    logic [2:0] alu_tab [logic [5:0]];
    int checks = 0;
    int errors = 0;
    int instr_id = 0;

    mc_controller #(.MEM_WAIT(MW), .WAIT_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol)
    );

    always #5 clk = ~clk;

    assign act = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                  alusrca, alusrcb, pcsrc, alucontrol};

    function automatic outs_t strobe_mask();
        outs_t m = '0;
        m.pcen = 1'b1; m.memwrite = 1'b1; m.irwrite = 1'b1; m.regwrite = 1'b1;
        return m;
    endfunction

    function automatic outs_t alu_mask();
        outs_t m = '0;
        m.alusrca = 1'b1; m.alusrcb = 2'b11; m.aluctl = 3'b111;
        return m;
    endfunction

    task automatic emit(input outs_t e, input outs_t m);
        entry_t x;
        x.e = e;
        x.m = m | strobe_mask();
        x.instr = instr_id;
        x.cyc = model_q.size();
        model_q.push_back(x);
    endtask

    task automatic emit_reset();
        outs_t e = '0;
        outs_t m = alu_mask();
        e.alusrcb = 2'b01;
        m.iord = 1'b1; m.pcsrc = 2'b11;
        emit(e, m);
    endtask

    // Instruction-level reference: one expected control word per clock of the instruction.
    task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z);
        outs_t e, m;
        logic known;
        model_q.delete();
        for (int i = 0; i <= MW; i++) begin
            e = '0; m = alu_mask();
            m.iord = 1'b1; m.pcsrc = 2'b11;
            e.alusrcb = 2'b01;
            e.irwrite = (i == MW);
            e.pcen = (i == MW);
            emit(e, m);
        end
        e = '0; m = alu_mask(); e.alusrcb = 2'b11;
        emit(e, m);
        if (o == OP_LW || o == OP_SW) begin
            e = '0; m = alu_mask(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
            emit(e, m);
            for (int i = 0; i <= MW; i++) begin
                e = '0; m = '0; m.iord = 1'b1; e.iord = 1'b1;
                e.memwrite = (o == OP_SW) && (i == MW);
                emit(e, m);
            end
            if (o == OP_LW) begin
                e = '0; m = '0; m.memtoreg = 1'b1; m.regdst = 1'b1;
                e.regwrite = 1'b1; e.memtoreg = 1'b1;
                emit(e, m);
            end
        end else if (o == OP_RTYPE) begin
            known = alu_tab.exists(f);
            e = '0; m = alu_mask(); e.alusrca = 1'b1;
            e.aluctl = known ? alu_tab[f] : 3'b000;
            emit(e, m);
            e = '0; m = '0; m.regdst = 1'b1; e.regdst = 1'b1; e.regwrite = known;
            emit(e, m);
`ifdef MC_CTRL_BNE_EN
        end else if (o == OP_BEQ || o == OP_BNE) begin
            e = '0; m = alu_mask(); m.pcsrc = 2'b11;
            e.alusrca = 1'b1; e.aluctl = 3'b011; e.pcsrc = 2'b01;
            e.pcen = (o == OP_BEQ) ? z : ~z;
            emit(e, m);
`else
        end else if (o == OP_BEQ) begin
            e = '0; m = alu_mask(); m.pcsrc = 2'b11;
            e.alusrca = 1'b1; e.aluctl = 3'b011; e.pcsrc = 2'b01; e.pcen = z;
            emit(e, m);
`endif
        end else if (o == OP_ADDI) begin
            e = '0; m = alu_mask(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
            emit(e, m);
            e = '0; m = '0; m.regdst = 1'b1; e.regwrite = 1'b1;
            emit(e, m);
        end else if (o == OP_J) begin
            e = '0; m = '0; m.pcsrc = 2'b11; e.pcsrc = 2'b10; e.pcen = 1'b1;
            emit(e, m);
        end
    endtask

    // Runs one instruction; cut > 0 aborts it with a reset pulse after that many cycles.
    task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input logic z,
                                 input int cut);
        int n;
        op = o; funct = f; zero = z;
        build(o, f, z);
        n = (cut > 0 && cut < model_q.size()) ? cut : model_q.size();
        for (int i = 0; i < n; i++) exp_q.push_back(model_q[i]);
        repeat (n) @(posedge clk);
        #1;
        if (n < model_q.size()) begin
            model_q.delete();
            emit_reset();
            exp_q.push_back(model_q[0]);
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
        end
        instr_id++;
    endtask

    task automatic checkOutput(input entry_t x);
        checks++;
        if (((act ^ x.e) & x.m) !== '0) begin
            errors++;
            $display("[TB] FAIL ctrl instr=%0d cyc=%0d actual=%h required=%h mask=%h",
                     x.instr, x.cyc, act, x.e, x.m);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_x = exp_q.pop_front();
            checkOutput(mon_x);
        end
    end

    initial begin
        logic [5:0] ops [0:7];
        logic [5:0] fns [0:5];
        logic [5:0] o, f;
        alu_tab[6'b100000] = 3'b000;
        alu_tab[6'b100100] = 3'b001;
        alu_tab[6'b100111] = 3'b010;
        alu_tab[6'b100010] = 3'b011;
        alu_tab[6'b101010] = 3'b101;
        ops[0] = OP_LW;  ops[1] = OP_SW;   ops[2] = OP_RTYPE; ops[3] = OP_BEQ;
        ops[4] = OP_BNE; ops[5] = OP_ADDI; ops[6] = OP_J;     ops[7] = 6'b111111;
        fns[0] = 6'b100000; fns[1] = 6'b100100; fns[2] = 6'b100111;
        fns[3] = 6'b100010; fns[4] = 6'b101010; fns[5] = 6'b000111;

        repeat (2) @(posedge clk);
        #1;
        model_q.delete();
        emit_reset();
        exp_q.push_back(model_q[0]);
        @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus(OP_RTYPE, 6'b100010, 1'b0, 0);
        applyStimulus(OP_BEQ, 6'b000000, 1'b1, 0);
        applyStimulus(OP_BEQ, 6'b000000, 1'b0, 0);
        applyStimulus(OP_LW, 6'b000000, 1'b0, 0);
        applyStimulus(OP_SW, 6'b000000, 1'b0, 0);
        applyStimulus(6'b111111, 6'b000000, 1'b0, 0);
        applyStimulus(OP_BNE, 6'b000000, 1'b0, 0);
        applyStimulus(OP_RTYPE, 6'b111111, 1'b0, 0);
        applyStimulus(OP_J, 6'b000000, 1'b0, 0);
        applyStimulus(OP_ADDI, 6'b000000, 1'b1, 0);
        applyStimulus(OP_LW, 6'b000000, 1'b0, MW + 4);
        applyStimulus(OP_RTYPE, 6'b101010, 1'b0, 0);

        for (int k = 0; k < 80; k++) begin
            o = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                            : ops[$urandom_range(0, 7)];
            f = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                            : fns[$urandom_range(0, 5)];
            applyStimulus(o, f, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 6)) : 0);
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain actual=%0d pending required=0 pending", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
